// File: rtl/mem_pkg.sv
// Shared opcode, flash-instruction and state definitions for the memory
// transaction engine.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_RD_KEY  = 2'b00,
        OP_RD_TEXT = 2'b01,
        OP_WR_RES  = 2'b10,
        OP_OTHER   = 2'b11
    } opcode_t;

    localparam logic [7:0] FL_READ  = 8'h03;
    localparam logic [7:0] FL_PP    = 8'h02;
    localparam logic [7:0] FL_WREN  = 8'h06;
    localparam logic [7:0] FL_RDSR  = 8'h05;
    localparam logic [7:0] FL_DUMMY = 8'h00;

    // IDLE wait cmd | WREN write-enable | GAP CS high | CMD opcode | ADDR 3 bytes
    // RD_DATA read | WR_DATA program | POLL_CMD 05 | POLL_RD status | DONE pulse
    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_CMD,
        S_ADDR,
        S_RD_DATA,
        S_WR_DATA,
        S_POLL_CMD,
        S_POLL_RD,
        S_DONE
    } state_t;

endpackage

// File: rtl/mem_transaction_fsm.sv
// Flash transaction engine: READ for key/text fetches, WREN + PAGE PROGRAM +
// RDSR polling for result writes, with byte streams to/from the command port.
module mem_transaction_fsm
    import mem_pkg::*;
#(
    parameter int KEY_BYTES  = 32,
    parameter int TEXT_BYTES = 16,
    parameter int RES_BYTES  = 32,
    parameter int CS_GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_cmd_valid,
    input  logic [7:0]  in_cmd_data,
    output logic        out_cmd_ready,
    input  logic [1:0]  in_opcode,
    input  logic        in_enc_type,
    input  logic [23:0] in_address,
    output logic        out_rd_valid,
    output logic [7:0]  out_rd_data,
    input  logic        in_rd_ready,
    output logic        out_fsm_done,
    output logic        out_enc_type,
    output logic        out_spi_start,
    output logic [7:0]  out_spi_tx,
    output logic        out_spi_cs_n,
    input  logic        in_spi_done,
    input  logic [7:0]  in_spi_rx
);

    localparam logic [5:0] KEY_LEN  = 6'(KEY_BYTES);
    localparam logic [5:0] TEXT_LEN = 6'(TEXT_BYTES);
    localparam logic [5:0] RES_LEN  = 6'(RES_BYTES);
    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    state_t      state, state_nxt, gap_ret;
    opcode_t     op_q;
    logic [23:0] addr_q;
    logic        enc_q;
    logic        busy;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [7:0]  gap_cnt;
    logic [5:0]  cnt;
    logic [5:0]  rd_len;
    logic [1:0]  addr_idx;
    logic        cmd_fire;

    assign rd_len       = (op_q == OP_RD_KEY) ? KEY_LEN : TEXT_LEN;
    assign cmd_fire     = in_cmd_valid && out_cmd_ready;
    assign out_rd_valid = rd_valid;
    assign out_rd_data  = rd_data;
    assign out_enc_type = enc_q;

    always_comb begin
        state_nxt     = state;
        out_cmd_ready = 1'b0;
        out_spi_start = 1'b0;
        out_spi_tx    = FL_DUMMY;
        out_spi_cs_n  = 1'b1;
        out_fsm_done  = 1'b0;
        case (state)
            S_IDLE: begin
                out_cmd_ready = !rst;
                if (in_cmd_valid && !rst) begin
                    case (opcode_t'(in_opcode))
                        OP_RD_KEY, OP_RD_TEXT: state_nxt = S_CMD;
                        OP_WR_RES:             state_nxt = S_WREN;
                        default:               state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WREN: begin
                out_spi_cs_n  = 1'b0;
                out_spi_start = !busy;
                out_spi_tx    = FL_WREN;
                if (in_spi_done) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == 8'd0) state_nxt = gap_ret;
            end
            S_CMD: begin
                out_spi_cs_n  = 1'b0;
                out_spi_start = !busy;
                out_spi_tx    = (op_q == OP_WR_RES) ? FL_PP : FL_READ;
                if (in_spi_done) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                out_spi_cs_n  = 1'b0;
                out_spi_start = !busy;
                case (addr_idx)
                    2'd0:    out_spi_tx = addr_q[23:16];
                    2'd1:    out_spi_tx = addr_q[15:8];
                    default: out_spi_tx = addr_q[7:0];
                endcase
                if (in_spi_done && addr_idx == 2'd2)
                    state_nxt = (op_q == OP_WR_RES) ? S_WR_DATA : S_RD_DATA;
            end
            S_RD_DATA: begin
                out_spi_cs_n  = 1'b0;
                // hold off the next byte until the output register has room
                out_spi_start = !busy && (cnt < rd_len) && (!rd_valid || in_rd_ready);
                if (cnt == rd_len && rd_valid && in_rd_ready) state_nxt = S_DONE;
            end
            S_WR_DATA: begin
                out_spi_cs_n  = 1'b0;
                out_cmd_ready = !busy && (cnt < RES_LEN);
                if (in_cmd_valid && out_cmd_ready) begin
                    out_spi_start = 1'b1;
                    out_spi_tx    = in_cmd_data;
                end
                if (in_spi_done && cnt == RES_LEN) state_nxt = S_GAP;
            end
            S_POLL_CMD: begin
                out_spi_cs_n  = 1'b0;
                out_spi_start = !busy;
                out_spi_tx    = FL_RDSR;
                if (in_spi_done) state_nxt = S_POLL_RD;
            end
            S_POLL_RD: begin
                out_spi_cs_n  = 1'b0;
                out_spi_start = !busy;
                if (in_spi_done && !in_spi_rx[0]) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_fsm_done = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gap_ret  <= S_CMD;
            gap_cnt  <= 8'd0;
            op_q     <= OP_RD_KEY;
            addr_q   <= 24'd0;
            enc_q    <= 1'b0;
            busy     <= 1'b0;
            cnt      <= 6'd0;
            addr_idx <= 2'd0;
            rd_valid <= 1'b0;
            rd_data  <= 8'd0;
        end else begin
            state <= state_nxt;

            if (out_spi_start)    busy <= 1'b1;
            else if (in_spi_done) busy <= 1'b0;

            if (state == S_IDLE && cmd_fire) begin
                op_q     <= opcode_t'(in_opcode);
                enc_q    <= in_enc_type;
                addr_q   <= in_address;
                cnt      <= 6'd0;
                addr_idx <= 2'd0;
            end

            if (state == S_ADDR && in_spi_done) addr_idx <= addr_idx + 2'd1;
            if (state == S_WR_DATA && cmd_fire) cnt <= cnt + 6'd1;

            if (state == S_RD_DATA && in_spi_done) begin
                rd_data  <= in_spi_rx;
                rd_valid <= 1'b1;
                cnt      <= cnt + 6'd1;
            end else if (rd_valid && in_rd_ready) begin
                rd_valid <= 1'b0;
            end

            if (state_nxt == S_GAP && state != S_GAP) begin
                gap_cnt <= GAP_LOAD;
                gap_ret <= (state == S_WREN) ? S_CMD : S_POLL_CMD;
            end else if (state == S_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_transaction_fsm.sv
// Directed bench for mem_transaction_fsm with a behavioural SPI shifter and
// a cycle monitor logging SPI bytes, CS gaps and read-channel handshakes.
`timescale 1ns/1ps
module tb_mem_transaction_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_cmd_valid;
    logic [7:0]  in_cmd_data;
    logic        out_cmd_ready;
    logic [1:0]  in_opcode;
    logic        in_enc_type;
    logic [23:0] in_address;
    logic        out_rd_valid;
    logic [7:0]  out_rd_data;
    logic        in_rd_ready;
    logic        out_fsm_done;
    logic        out_enc_type;
    logic        out_spi_start;
    logic [7:0]  out_spi_tx;
    logic        out_spi_cs_n;
    logic        in_spi_done;
    logic [7:0]  in_spi_rx;

    mem_transaction_fsm dut (
        .clk(clk), .rst(rst),
        .in_cmd_valid(in_cmd_valid), .in_cmd_data(in_cmd_data), .out_cmd_ready(out_cmd_ready),
        .in_opcode(in_opcode), .in_enc_type(in_enc_type), .in_address(in_address),
        .out_rd_valid(out_rd_valid), .out_rd_data(out_rd_data), .in_rd_ready(in_rd_ready),
        .out_fsm_done(out_fsm_done), .out_enc_type(out_enc_type),
        .out_spi_start(out_spi_start), .out_spi_tx(out_spi_tx), .out_spi_cs_n(out_spi_cs_n),
        .in_spi_done(in_spi_done), .in_spi_rx(in_spi_rx)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int cyc = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] rx_q[$];
    int gap_q[$];
    int start_cyc_q[$];
    int cs_bad = 0, ovl_cnt = 0, stab_err = 0;
    int done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, last_sd_cyc = 0, acc_cyc = 0;
    int cs_hi_run = 0;
    logic [7:0] last_rx = 8'h00;
    logic mon_busy = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // SPI shifter: done pulse two cycles after each start, rx from rx_q
    initial begin : spi_model
        bit pend;
        int dly;
        pend = 0;
        dly  = 0;
        forever begin
            @(negedge clk);
            in_spi_done = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    in_spi_done = 1'b1;
                    if (rx_q.size() != 0) in_spi_rx = rx_q.pop_front();
                    else                  in_spi_rx = 8'h00;
                    pend = 0;
                end else begin
                    dly--;
                end
            end
            #2;
            if (rst) pend = 0;
            else if (out_spi_start) begin
                pend = 1;
                dly  = 1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (out_spi_start) begin
                if (mon_busy) ovl_cnt++;
                if (out_spi_cs_n) cs_bad++;
                tx_q.push_back(out_spi_tx);
                gap_q.push_back(cs_hi_run);
                start_cyc_q.push_back(cyc);
            end
            if (in_spi_done) begin
                last_sd_cyc = cyc;
                last_rx     = in_spi_rx;
            end
            if (rst) mon_busy = 1'b0;
            else begin
                if (in_spi_done)   mon_busy = 1'b0;
                if (out_spi_start) mon_busy = 1'b1;
            end
            cs_hi_run = out_spi_cs_n ? cs_hi_run + 1 : 0;
            if (!rst && prev_valid && !prev_ready &&
                (!out_rd_valid || out_rd_data != prev_data)) stab_err++;
            if (out_rd_valid && in_rd_ready) begin
                rd_q.push_back(out_rd_data);
                last_hs_cyc = cyc;
            end
            prev_valid = out_rd_valid;
            prev_ready = in_rd_ready;
            prev_data  = out_rd_data;
            if (in_cmd_valid && out_cmd_ready) acc_cyc = cyc;
            if (out_fsm_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        tx_q.delete();
        rd_q.delete();
        rx_q.delete();
        gap_q.delete();
        start_cyc_q.delete();
        cs_bad   = 0;
        ovl_cnt  = 0;
        stab_err = 0;
    endtask

    task automatic load_read_rx(input logic [7:0] base, input int n);
        for (int i = 0; i < 4; i++) rx_q.push_back(8'h00);
        for (int i = 0; i < n; i++) rx_q.push_back(8'(base + i));
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic enc, input logic [23:0] a);
        in_opcode    = op;
        in_enc_type  = enc;
        in_address   = a;
        in_cmd_data  = {6'd0, op};
        in_cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #3;
            if (out_cmd_ready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_cmd_valid = 1'b0;
    endtask

    function automatic logic [7:0] exp_wr(input int i);
        logic [7:0] b;
        case (i)
            0:       b = 8'h06;
            1:       b = 8'h02;
            2:       b = 8'h00;
            3:       b = 8'h01;
            4:       b = 8'h00;
            37:      b = 8'h05;
            default: b = (i >= 5 && i < 37) ? 8'(8'hA0 + i - 5) : 8'h00;
        endcase
        return b;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        #3;
        total++;
        if (out_spi_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", out_spi_cs_n);
        else passed++;
        total++;
        if ({out_cmd_ready, out_rd_valid, out_fsm_done, out_enc_type, out_spi_start} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {out_cmd_ready, out_rd_valid, out_fsm_done, out_enc_type, out_spi_start});
        else passed++;
        total++;
        if ({out_rd_data, out_spi_tx} !== 16'h0000)
            $display("FAIL reset_data: got %h want 0000", {out_rd_data, out_spi_tx});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        total++;
        if (out_cmd_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", out_cmd_ready);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_rd_key();
        int d0, bad;
        logic [7:0] hdr [4];
        hdr = '{8'h03, 8'h01, 8'h23, 8'h45};
        clear_logs();
        load_read_rx(8'h00, 32);
        in_rd_ready = 1'b1;
        d0 = done_cnt;
        send_cmd(2'b00, 1'b1, 24'h012345);
        for (int i = 0; i < 2000 && done_cnt == d0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt !== d0 + 1) $display("FAIL rdkey_done_count: got %0d want %0d", done_cnt - d0, 1);
        else passed++;
        total++;
        if (tx_q.size() !== 36) $display("FAIL rdkey_tx_len: got %0d want 36", tx_q.size());
        else passed++;
        bad = 0;
        for (int i = 0; i < tx_q.size(); i++)
            if (tx_q[i] !== ((i < 4) ? hdr[i] : 8'h00)) bad++;
        total++;
        if (bad !== 0) $display("FAIL rdkey_tx_bytes: got %0d wrong bytes want 0", bad);
        else passed++;
        bad = 0;
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== 8'(i)) bad++;
        total++;
        if (rd_q.size() !== 32 || bad !== 0)
            $display("FAIL rdkey_rd_bytes: got %0d bytes %0d wrong want 32 bytes 0 wrong", rd_q.size(), bad);
        else passed++;
        total++;
        if (cs_bad !== 0 || ovl_cnt !== 0)
            $display("FAIL rdkey_spi_protocol: got cs_bad=%0d overlap=%0d want 0 0", cs_bad, ovl_cnt);
        else passed++;
        total++;
        if (start_cyc_q.size() == 0 || start_cyc_q[0] - acc_cyc !== 1)
            $display("FAIL rdkey_first_start_latency: got %0d want 1",
                     (start_cyc_q.size() == 0) ? -1 : start_cyc_q[0] - acc_cyc);
        else passed++;
        total++;
        if (done_cyc - last_hs_cyc !== 1)
            $display("FAIL rdkey_done_latency: got %0d want 1", done_cyc - last_hs_cyc);
        else passed++;
        total++;
        if (out_enc_type !== 1'b1) $display("FAIL rdkey_enc_type: got %b want 1", out_enc_type);
        else passed++;
    endtask

    task automatic test_rd_text_stall();
        int d0, bad, st_starts, st_cs;
        clear_logs();
        load_read_rx(8'h40, 16);
        in_rd_ready = 1'b1;
        d0 = done_cnt;
        send_cmd(2'b01, 1'b0, 24'h000040);
        for (int i = 0; i < 500 && rd_q.size() < 3; i++) begin
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        in_rd_ready = 1'b0;
        st_starts = 0;
        st_cs     = 0;
        repeat (10) begin
            #3;
            if (out_spi_start) st_starts++;
            if (out_spi_cs_n)  st_cs++;
            @(negedge clk);
        end
        in_rd_ready = 1'b1;
        #3;
        total++;
        if (out_rd_valid !== 1'b1 || out_rd_data !== 8'h43)
            $display("FAIL stall_held_byte: got valid=%b data=%h want 1 43", out_rd_valid, out_rd_data);
        else passed++;
        total++;
        if (st_starts !== 0) $display("FAIL stall_no_start: got %0d starts want 0", st_starts);
        else passed++;
        total++;
        if (st_cs !== 0) $display("FAIL stall_cs_low: got %0d cs-high cycles want 0", st_cs);
        else passed++;
        for (int i = 0; i < 2000 && done_cnt == d0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== 8'(8'h40 + i)) bad++;
        total++;
        if (rd_q.size() !== 16 || bad !== 0)
            $display("FAIL stall_rd_bytes: got %0d bytes %0d wrong want 16 bytes 0 wrong", rd_q.size(), bad);
        else passed++;
        total++;
        if (stab_err !== 0) $display("FAIL stall_valid_stable: got %0d violations want 0", stab_err);
        else passed++;
        total++;
        if (done_cnt !== d0 + 1) $display("FAIL stall_done_count: got %0d want 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_wr_res();
        int d0, bad, poll_gap;
        clear_logs();
        for (int i = 0; i < 38; i++) rx_q.push_back(8'h00);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h00);
        d0 = done_cnt;
        send_cmd(2'b10, 1'b0, 24'h000100);
        for (int b = 0; b < 32; b++) begin
            in_cmd_data  = 8'(8'hA0 + b);
            in_cmd_valid = 1'b1;
            for (int i = 0; i < 200; i++) begin
                #3;
                if (out_cmd_ready) break;
                @(negedge clk);
            end
            @(negedge clk);
        end
        in_cmd_valid = 1'b0;
        for (int i = 0; i < 2000 && done_cnt == d0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++;
        if (tx_q.size() !== 42) $display("FAIL wr_tx_len: got %0d want 42", tx_q.size());
        else passed++;
        bad = 0;
        for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] !== exp_wr(i)) bad++;
        total++;
        if (bad !== 0) $display("FAIL wr_tx_bytes: got %0d wrong bytes want 0", bad);
        else passed++;
        total++;
        if (gap_q.size() < 2 || gap_q[1] < 2)
            $display("FAIL wr_gap_after_wren: got %0d want >=2", (gap_q.size() < 2) ? -1 : gap_q[1]);
        else passed++;
        total++;
        if (gap_q.size() < 38 || gap_q[37] < 2)
            $display("FAIL wr_gap_before_rdsr: got %0d want >=2", (gap_q.size() < 38) ? -1 : gap_q[37]);
        else passed++;
        poll_gap = 0;
        for (int i = 38; i < gap_q.size(); i++) poll_gap += gap_q[i];
        total++;
        if (gap_q.size() !== 42 || poll_gap !== 0)
            $display("FAIL wr_poll_cs_held: got %0d cs-high cycles over %0d starts want 0 over 42",
                     poll_gap, gap_q.size());
        else passed++;
        total++;
        if (done_cnt !== d0 + 1) $display("FAIL wr_done_count: got %0d want 1", done_cnt - d0);
        else passed++;
        total++;
        if (done_cyc - last_sd_cyc !== 1 || last_rx !== 8'h00)
            $display("FAIL wr_done_latency: got %0d after status %h want 1 after 00",
                     done_cyc - last_sd_cyc, last_rx);
        else passed++;
        total++;
        if (cs_bad !== 0 || ovl_cnt !== 0)
            $display("FAIL wr_spi_protocol: got cs_bad=%0d overlap=%0d want 0 0", cs_bad, ovl_cnt);
        else passed++;
    endtask

    task automatic test_opcode_other();
        int d0;
        clear_logs();
        d0 = done_cnt;
        send_cmd(2'b11, 1'b0, 24'h0000AA);
        repeat (20) @(negedge clk);
        #3;
        total++;
        if (tx_q.size() !== 0) $display("FAIL other_no_spi: got %0d starts want 0", tx_q.size());
        else passed++;
        total++;
        if (done_cnt !== d0) $display("FAIL other_no_done: got %0d pulses want 0", done_cnt - d0);
        else passed++;
        total++;
        if (out_cmd_ready !== 1'b1 || out_spi_cs_n !== 1'b1)
            $display("FAIL other_idle: got ready=%b cs_n=%b want 1 1", out_cmd_ready, out_spi_cs_n);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int d0, bad;
        logic [7:0] hdr [4];
        hdr = '{8'h03, 8'h00, 8'h02, 8'h00};
        clear_logs();
        load_read_rx(8'h50, 16);
        in_rd_ready = 1'b1;
        d0 = done_cnt;
        send_cmd(2'b01, 1'b0, 24'hABCDEF);
        for (int i = 0; i < 200 && tx_q.size() < 3; i++) begin
            @(negedge clk);
            #3;
        end
        total++;
        if (tx_q.size() !== 3 || out_spi_cs_n !== 1'b0)
            $display("FAIL rstmid_in_addr: got %0d bytes cs_n=%b want 3 0", tx_q.size(), out_spi_cs_n);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (out_spi_cs_n !== 1'b1 || out_spi_start !== 1'b0 || out_rd_valid !== 1'b0)
            $display("FAIL rstmid_async: got cs_n=%b start=%b valid=%b want 1 0 0",
                     out_spi_cs_n, out_spi_start, out_rd_valid);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt !== d0) $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0);
        else passed++;

        clear_logs();
        load_read_rx(8'h60, 16);
        send_cmd(2'b01, 1'b0, 24'h000200);
        for (int i = 0; i < 2000 && done_cnt == d0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 4 && i < tx_q.size(); i++) if (tx_q[i] !== hdr[i]) bad++;
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== 8'(8'h60 + i)) bad++;
        total++;
        if (tx_q.size() !== 20 || rd_q.size() !== 16 || bad !== 0)
            $display("FAIL rstmid_recover: got tx=%0d rd=%0d wrong=%0d want 20 16 0",
                     tx_q.size(), rd_q.size(), bad);
        else passed++;
        total++;
        if (done_cnt !== d0 + 1) $display("FAIL rstmid_recover_done: got %0d want 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_coincident();
        int d0, bad;
        logic [7:0] pat;
        pat = 8'b1001_0110;
        clear_logs();
        load_read_rx(8'h80, 16);
        in_rd_ready = 1'b0;
        d0 = done_cnt;
        send_cmd(2'b01, 1'b1, 24'h000300);
        for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
            #1;
            in_rd_ready = in_spi_done | pat[i % 8];
            @(negedge clk);
        end
        in_rd_ready = 1'b1;
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== 8'(8'h80 + i)) bad++;
        total++;
        if (rd_q.size() !== 16 || bad !== 0)
            $display("FAIL coinc_rd_bytes: got %0d bytes %0d wrong want 16 bytes 0 wrong", rd_q.size(), bad);
        else passed++;
        total++;
        if (stab_err !== 0 || ovl_cnt !== 0)
            $display("FAIL coinc_protocol: got stab=%0d overlap=%0d want 0 0", stab_err, ovl_cnt);
        else passed++;
        total++;
        if (done_cnt !== d0 + 1) $display("FAIL coinc_done_count: got %0d want 1", done_cnt - d0);
        else passed++;
        total++;
        if (done_cyc - last_hs_cyc !== 1)
            $display("FAIL coinc_done_latency: got %0d want 1", done_cyc - last_hs_cyc);
        else passed++;
    endtask

    initial begin
        rst          = 1'b1;
        in_cmd_valid = 1'b0;
        in_cmd_data  = 8'h00;
        in_opcode    = 2'b00;
        in_enc_type  = 1'b0;
        in_address   = 24'h0;
        in_rd_ready  = 1'b0;
        in_spi_done  = 1'b0;
        in_spi_rx    = 8'h00;
        test_reset();
        test_rd_key();
        test_rd_text_stall();
        test_wr_res();
        test_opcode_other();
        test_reset_mid();
        test_coincident();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
